alu_pipe: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output, status flags,
//  and an iterative multiplier. Successor to the 8-bit combinational ALU. Sits between the

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 51 +++++
 rtl/alu_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpSltu = 4'd4,
        OpXor  = 4'd5,
        OpShl  = 4'd6,
        OpShr  = 4'd7,
        OpMul  = 4'd8,
        OpSra  = 4'd9,
        OpSlt  = 4'd10,
        OpRol  = 4'd11
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, done after WIDTH iterations.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               active;

    assign done    = active && (cnt == CW'(WIDTH));
    assign product = prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (done) begin
            // The top consumes the product on this same edge.
            active <= 1'b0;
        end else if (active) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, {V,C,N,Z} flags and an optional iterative MUL.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e state;

    logic                   accept, is_mul, mul_start, mul_done, load_alu;
    logic [2*WIDTH-1:0]     mul_prod;
    logic [WIDTH-1:0]       alu_res, rol_res, diff;
    logic                   alu_c, alu_v;
    logic [WIDTH:0]         sum, shl_ext, shr_ext;
    logic signed [WIDTH:0]  sra_ext;
    logic [SHW-1:0]         sh, rot;
    logic [3:0]             alu_flags, mul_flags;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OpMul) && MUL_EN;
    assign mul_start = accept && is_mul;
    assign load_alu  = accept && !is_mul;

    assign sh  = b[SHW-1:0];
    assign rot = SHW'(32'(sh) % WIDTH);

    // Shifts carry one guard bit so the last bit shifted out lands at a fixed position.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = a - b;
        shl_ext = {1'b0, a} << sh;
        shr_ext = {a, 1'b0} >> sh;
        sra_ext = $signed({a, 1'b0}) >>> sh;
        rol_res = (a << rot) | (a >> (WIDTH - 32'(rot)));
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OpAdd: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_c   = a < b;
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd:  alu_res = a & b;
            OpOr:   alu_res = a | b;
            OpXor:  alu_res = a ^ b;
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OpShl: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OpShr: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            OpSra: begin
                alu_res = sra_ext[WIDTH:1];
                alu_c   = sra_ext[0];
            end
            OpRol:  alu_res = rol_res;
            default: ;
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
        mul_flags[FLAG_N] = mul_prod[WIDTH-1];
        mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    end

    if (MUL_EN) begin : g_mul
        alu_mul_iter #(
            .WIDTH(WIDTH)
        ) u_mul (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (mul_start),
            .a      (a),
            .b      (b),
            .done   (mul_done),
            .product(mul_prod)
        );
    end else begin : g_no_mul
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: if (mul_start) begin
                    state <= MUL;
                    busy  <= 1'b1;
                end
                MUL: if (mul_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (load_alu) begin
                result    <= alu_res;
                flags     <= alu_flags;
                out_valid <= 1'b1;
            end else if (state == MUL && mul_done) begin
                result    <= mul_prod[WIDTH-1:0];
                flags     <= mul_flags;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: WIDTH=8 with iterative MUL and WIDTH=16 with MUL disabled.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8, iv16, out_ready;
    logic [3:0]  op;
    logic [63:0] a_drv, b_drv;
    logic        ir8, ov8, busy8, ir16, ov16, busy16;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [3:0]  fl8, fl16;

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .out_valid(ov8), .out_ready(out_ready),
        .result(res8), .flags(fl8), .busy(busy8)
    );

    alu_pipe #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .out_valid(ov16), .out_ready(out_ready),
        .result(res16), .flags(fl16), .busy(busy16)
    );

    bit          sel16;
    logic        s_ready, s_valid;
    logic [63:0] s_res;
    logic [3:0]  s_fl;
    assign s_ready = sel16 ? ir16 : ir8;
    assign s_valid = sel16 ? ov16 : ov8;
    assign s_res   = sel16 ? {48'b0, res16} : {56'b0, res8};
    assign s_fl    = sel16 ? fl16 : fl8;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        bit          w16;
        logic [3:0]  op;
        logic [63:0] a, b, res;
        logic [3:0]  fl;
        int          lat;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit w16, input logic [3:0] o, input logic [63:0] x,
                           input logic [63:0] y, input logic [63:0] r, input logic [3:0] f,
                           input int l, input string n);
        tbl.push_back('{w16, o, x, y, r, f, l, n});
    endtask

    // Presents one request and returns the number of edges after the accept edge until out_valid.
    task automatic issue(input bit w16, input logic [3:0] o, input logic [63:0] x,
                         input logic [63:0] y, output int lat);
        int n = 0;
        sel16 = w16;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("ready_timeout", 64'(s_ready), 64'd1);
        op = o; a_drv = x; b_drv = y;
        if (w16) iv16 = 1'b1; else iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; iv16 = 1'b0;
        lat = 0;
        while (!s_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [11:0] model8(input logic [3:0] o, input logic [7:0] x,
                                           input logic [7:0] y);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0;
        if (o == OpAdd) begin
            s = {1'b0, x} + {1'b0, y};
            r = s[7:0];
            c = s[8];
            v = (x[7] == y[7]) && (r[7] != x[7]);
        end else begin
            r = x ^ y;
        end
        return {v, c, r[7], (r == 8'h00), r};
    endfunction

    initial begin
        int lat;
        logic [7:0] ra[16], rb[16];
        logic [3:0] rop[16];
        logic [11:0] m;
        logic seen;

        iv8 = 1'b0; iv16 = 1'b0; out_ready = 1'b1; op = '0; a_drv = '0; b_drv = '0;
        sel16 = 1'b0;

        #2;
        check("rst_out_valid", 64'({ov8, ov16}), 64'd0);
        check("rst_result", 64'({res8, res16}), 64'd0);
        check("rst_flags", 64'({fl8, fl16}), 64'd0);
        check("rst_busy", 64'({busy8, busy16}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'({ir8, ir16}), 64'd3);
        @(negedge clk);

        add_vec(0, OpAdd,  64'hF0, 64'h20, 64'h10, 4'b0100, 0, "add_carry");
        add_vec(0, OpAdd,  64'h7F, 64'h01, 64'h80, 4'b1010, 0, "add_ovf");
        add_vec(0, OpSub,  64'h80, 64'h01, 64'h7F, 4'b1000, 0, "sub_ovf");
        add_vec(0, OpSub,  64'h01, 64'h02, 64'hFF, 4'b0110, 0, "sub_borrow");
        add_vec(0, OpSlt,  64'hFF, 64'h01, 64'h01, 4'b0000, 0, "slt");
        add_vec(0, OpSltu, 64'hFF, 64'h01, 64'h00, 4'b0001, 0, "sltu");
        add_vec(0, OpAnd,  64'hF0, 64'h3C, 64'h30, 4'b0000, 0, "and");
        add_vec(0, OpOr,   64'h0F, 64'hF0, 64'hFF, 4'b0010, 0, "or");
        add_vec(0, OpMul,  64'h10, 64'h10, 64'h00, 4'b0101, 9, "mul_hi");
        add_vec(0, OpSra,  64'h80, 64'h0B, 64'hF0, 4'b0010, 0, "sra");
        add_vec(0, OpRol,  64'h81, 64'h01, 64'h03, 4'b0000, 0, "rol");
        add_vec(0, OpShl,  64'h81, 64'h01, 64'h02, 4'b0100, 0, "shl");
        add_vec(0, OpShr,  64'h81, 64'h01, 64'h40, 4'b0100, 0, "shr");
        add_vec(0, OpShl,  64'hA5, 64'h08, 64'hA5, 4'b0010, 0, "shl_zero");
        add_vec(0, 4'd13,  64'h5A, 64'h33, 64'h00, 4'b0001, 0, "op13");
        add_vec(1, OpAdd,  64'hF000, 64'h2000, 64'h1000, 4'b0100, 0, "w16_add");
        add_vec(1, OpMul,  64'h000F, 64'h0011, 64'h0000, 4'b0001, 0, "w16_mul_off");
        add_vec(1, OpSra,  64'h8000, 64'h0013, 64'hF000, 4'b0010, 0, "w16_sra");
        add_vec(1, OpRol,  64'h8001, 64'h0001, 64'h0003, 4'b0000, 0, "w16_rol");
        add_vec(1, OpShl,  64'h8001, 64'h0001, 64'h0002, 4'b0100, 0, "w16_shl");
        add_vec(1, 4'd13,  64'h1234, 64'h0001, 64'h0000, 4'b0001, 0, "w16_op13");

        foreach (tbl[i]) begin
            issue(tbl[i].w16, tbl[i].op, tbl[i].a, tbl[i].b, lat);
            check({tbl[i].name, "_res"}, s_res, tbl[i].res);
            check({tbl[i].name, "_flags"}, 64'(s_fl), 64'(tbl[i].fl));
            check({tbl[i].name, "_lat"}, 64'(lat), 64'(tbl[i].lat));
        end

        // MUL 0F*11: stalled and busy for 9 edges, then result with input side free again.
        sel16 = 1'b0;
        @(posedge clk); #1;
        op = OpMul; a_drv = 64'h0F; b_drv = 64'h11; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("mul_wait", 64'({busy8, ir8, ov8}), 64'b100);
            @(posedge clk); #1;
        end
        check("mul_done", 64'({busy8, ir8, ov8}), 64'b011);
        check("mul_res", 64'(res8), 64'hFF);
        check("mul_flags", 64'(fl8), 64'b0010);

        // Back-to-back ADD/XOR at full throughput.
        for (int i = 0; i < 16; i++) begin
            ra[i]  = 8'($urandom);
            rb[i]  = 8'($urandom);
            rop[i] = ($urandom_range(0, 1) == 0) ? OpAdd : OpXor;
        end
        op = rop[0]; a_drv = 64'(ra[0]); b_drv = 64'(rb[0]); iv8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            m = model8(rop[i], ra[i], rb[i]);
            check("b2b_valid", 64'(ov8), 64'd1);
            check("b2b_res", 64'(res8), 64'(m[7:0]));
            check("b2b_flags", 64'(fl8), 64'(m[11:8]));
            if (i < 15) begin
                op = rop[i+1]; a_drv = 64'(ra[i+1]); b_drv = 64'(rb[i+1]);
            end else begin
                iv8 = 1'b0;
            end
        end

        // Backpressure: first result held, second request waits, then flows exactly once.
        @(posedge clk); #1;
        out_ready = 1'b0;
        op = OpAdd; a_drv = 64'h01; b_drv = 64'h01; iv8 = 1'b1;
        @(posedge clk); #1;
        a_drv = 64'h05; b_drv = 64'h06;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", 64'({ov8, ir8, res8}), {54'b0, 2'b10, 8'h02});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("bp_second", 64'({ov8, res8}), {55'b0, 1'b1, 8'h0B});
        @(posedge clk); #1;
        check("bp_no_dup", 64'(ov8), 64'd0);

        // Reset in the middle of a MUL.
        op = OpMul; a_drv = 64'h03; b_drv = 64'h05; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mul_clear", 64'({ov8, busy8}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen = seen | ov8 | busy8;
        end
        check("rst_no_result", 64'(seen), 64'd0);
        issue(0, OpAdd, 64'h03, 64'h04, lat);
        check("post_rst_add", 64'({ov8, res8}), {55'b0, 1'b1, 8'h07});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
